// File: rtl/if_id_register_pkg.sv
// Shared constants for the IF/ID stage, sign extender and controller:
// bubble word, 5-bit primary opcodes and imSrcSelect codes.
package if_id_register_pkg;

  localparam logic [15:0] NOP_WORD = 16'h0800;

  localparam logic [4:0] ADDIU   = 5'b01001;
  localparam logic [4:0] ADDIU3  = 5'b01000;
  localparam logic [4:0] B       = 5'b00010;
  localparam logic [4:0] BEQZ    = 5'b00100;
  localparam logic [4:0] BNEZ    = 5'b00101;
  localparam logic [4:0] LI      = 5'b01101;
  localparam logic [4:0] LW      = 5'b10011;
  localparam logic [4:0] SW      = 5'b11011;
  localparam logic [4:0] LW_SP   = 5'b10010;
  localparam logic [4:0] SW_SP   = 5'b11010;
  localparam logic [4:0] SLTI    = 5'b01010;
  localparam logic [4:0] CMPI    = 5'b01110;
  localparam logic [4:0] SHIFT   = 5'b00110;
  localparam logic [4:0] OP01100 = 5'b01100;

  // Sub-opcodes in [10:8] of OP01100 that take a signed 8-bit immediate
  localparam logic [2:0] SUB_BTEQZ = 3'b000;
  localparam logic [2:0] SUB_ADDSP = 3'b011;

  // bit 3 = sign-extend, bits 2:0 = immediate field
  localparam logic [3:0] IMM_S8    = 4'b1000;
  localparam logic [3:0] IMM_S4    = 4'b1001;
  localparam logic [3:0] IMM_S5    = 4'b1010;
  localparam logic [3:0] IMM_S11   = 4'b1011;
  localparam logic [3:0] IMM_Z8    = 4'b0000;
  localparam logic [3:0] IMM_SHAMT = 4'b0101;

endpackage

// File: rtl/if_id_register_imm_select_predecoder.sv
// Combinational opcode -> imSrcSelect code for the ID-stage sign extender.
module imm_select_predecoder
  import if_id_register_pkg::*;
(
  input  logic [4:0] i_opcode,
  input  logic [2:0] i_subop,
  output logic [3:0] o_imm_sel
);

  always_comb begin
    o_imm_sel = IMM_Z8;
    case (i_opcode)
      ADDIU, BEQZ, BNEZ, SLTI, CMPI, LW_SP, SW_SP: o_imm_sel = IMM_S8;
      OP01100: begin
        if ((i_subop == SUB_BTEQZ) || (i_subop == SUB_ADDSP))
          o_imm_sel = IMM_S8;
      end
      ADDIU3:  o_imm_sel = IMM_S4;
      LW, SW:  o_imm_sel = IMM_S5;
      B:       o_imm_sel = IMM_S11;
      LI:      o_imm_sel = IMM_Z8;
      SHIFT:   o_imm_sel = IMM_SHAMT;
      default: o_imm_sel = IMM_Z8;
    endcase
  end

endmodule

// File: rtl/if_id_register.sv
// IF/ID pipeline register with stall hold, flush/empty-fetch bubbles and,
// when IMM_PREDECODE_EN is defined, a registered imSrcSelect pre-decode.
module if_id_register
  import if_id_register_pkg::*;
#(
  parameter logic [15:0] NOP_WORD = if_id_register_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instructionIn,
  input  logic [15:0] pcPlusOneIn,
  input  logic        fetchValid,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] instructionOut,
  output logic [15:0] pcPlusOneOut,
  output logic        validOut,
  output logic [3:0]  imSrcSelectOut
);

  logic [15:0] r_instr;
  logic [15:0] r_pc;
  logic        r_valid;
  logic        w_bubble;
  logic        w_load;

  // flush beats stall; an empty fetch only bubbles when not stalled
  assign w_bubble = flush || (!stall && !fetchValid);
  assign w_load   = !flush && !stall && fetchValid;

  always_ff @(posedge clk) begin
    if (!rst || w_bubble) begin
      r_instr <= NOP_WORD;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_instr <= instructionIn;
      r_pc    <= pcPlusOneIn;
      r_valid <= 1'b1;
    end
  end

`ifdef IMM_PREDECODE_EN
  logic [3:0] w_imm_sel;
  logic [3:0] r_imm_sel;

  imm_select_predecoder u_predecoder (
    .i_opcode  (instructionIn[15:11]),
    .i_subop   (instructionIn[10:8]),
    .o_imm_sel (w_imm_sel)
  );

  always_ff @(posedge clk) begin
    if (!rst || w_bubble)
      r_imm_sel <= IMM_Z8;
    else if (w_load)
      r_imm_sel <= w_imm_sel;
  end

  assign imSrcSelectOut = r_imm_sel;
`else
  assign imSrcSelectOut = '0;
`endif

  assign instructionOut = r_instr;
  assign pcPlusOneOut   = r_pc;
  assign validOut       = r_valid;

endmodule
